// File: rtl/spwm_pkg.sv
// spwm_pkg: shared types, default geometry and helpers for the sine-PWM burst sequencer.
package spwm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    REST = 2'd2
  } state_e;

  localparam int unsigned THETA_W_DEF    = 10;
  localparam int unsigned THETA_LAST_DEF = 87;

  // Increment v, holding at the all-ones value of a w-bit counter (w <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v == max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/spwm_step_div.sv
// spwm_step_div: loadable rate divider. Counts 0..div-1 while enabled and
// pulses tick on the last count; div==0 behaves as 1. clr forces the count to 0.
module spwm_step_div #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] div,
  output logic         tick
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] last;

  // Terminal count detection and next count.
  always_comb begin
    last  = (div == '0) ? '0 : div - W'(1);
    tick  = en && !clr && (cnt_q == last);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spwm_burst_sequencer.sv
// spwm_burst_sequencer: steps the sine-table index, counts half-sine bursts and
// inserts rest gaps. Optional SPWM_POLARITY_EN toggles polarity at each burst end.
module spwm_burst_sequencer
  import spwm_pkg::*;
#(
  parameter int unsigned THETA_W    = THETA_W_DEF,
  parameter int unsigned THETA_LAST = THETA_LAST_DEF,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned REST_W     = 20,
  parameter int unsigned BURST_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   cfg_step_div,
  input  logic [REST_W-1:0]  cfg_rest,
  input  logic [BURST_W-1:0] cfg_bursts,
  output logic [THETA_W-1:0] theta,
  output logic               pwm_en,
  output logic               polarity,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] burst_cnt
);

  state_e               state_q, state_d;
  logic [THETA_W-1:0]   theta_q, theta_d;
  logic                 pwm_en_q, pwm_en_d;
  logic                 done_q, done_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [REST_W-1:0]    rest_q, rest_d;
  logic [BURST_W-1:0]   bursts_q, bursts_d;
  logic [BURST_W-1:0]   burst_next;
  logic                 step_tick, rest_tick;
`ifdef SPWM_POLARITY_EN
  logic                 pol_q, pol_d;
`endif

  spwm_step_div #(.W(DIV_W)) u_step_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != RUN),
    .en    (state_q == RUN),
    .div   (div_q),
    .tick  (step_tick)
  );

  spwm_step_div #(.W(REST_W)) u_rest_div (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != REST),
    .en    (state_q == REST),
    .div   (rest_q),
    .tick  (rest_tick)
  );

  // Next-state and registered-output logic; stop overrides everything.
  always_comb begin
    state_d     = state_q;
    theta_d     = theta_q;
    pwm_en_d    = pwm_en_q;
    done_d      = 1'b0;
    burst_cnt_d = burst_cnt_q;
    div_d       = div_q;
    rest_d      = rest_q;
    bursts_d    = bursts_q;
    burst_next  = BURST_W'(sat_inc(32'(burst_cnt_q), BURST_W));
`ifdef SPWM_POLARITY_EN
    pol_d       = pol_q;
`endif
    if (stop) begin
      state_d  = IDLE;
      theta_d  = '0;
      pwm_en_d = 1'b0;
`ifdef SPWM_POLARITY_EN
      pol_d    = 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d     = RUN;
            theta_d     = '0;
            pwm_en_d    = 1'b1;
            burst_cnt_d = '0;
            div_d       = cfg_step_div;
            rest_d      = cfg_rest;
            bursts_d    = cfg_bursts;
`ifdef SPWM_POLARITY_EN
            pol_d       = 1'b0;
`endif
          end
        end
        RUN: begin
          if (step_tick) begin
            if (theta_q == THETA_W'(THETA_LAST)) begin
              theta_d     = '0;
              burst_cnt_d = burst_next;
`ifdef SPWM_POLARITY_EN
              pol_d       = ~pol_q;
`endif
              if ((bursts_q != '0) && (burst_next == bursts_q)) begin
                state_d  = IDLE;
                pwm_en_d = 1'b0;
                done_d   = 1'b1;
              end else if (rest_q != '0) begin
                state_d  = REST;
                pwm_en_d = 1'b0;
              end
            end else begin
              theta_d = theta_q + THETA_W'(1);
            end
          end
        end
        REST: begin
          theta_d  = '0;
          pwm_en_d = 1'b0;
          if (rest_tick) begin
            state_d  = RUN;
            pwm_en_d = 1'b1;
          end
        end
        default: begin
          state_d  = IDLE;
          theta_d  = '0;
          pwm_en_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      theta_q     <= '0;
      pwm_en_q    <= 1'b0;
      done_q      <= 1'b0;
      burst_cnt_q <= '0;
      div_q       <= '0;
      rest_q      <= '0;
      bursts_q    <= '0;
    end else begin
      state_q     <= state_d;
      theta_q     <= theta_d;
      pwm_en_q    <= pwm_en_d;
      done_q      <= done_d;
      burst_cnt_q <= burst_cnt_d;
      div_q       <= div_d;
      rest_q      <= rest_d;
      bursts_q    <= bursts_d;
    end
  end

`ifdef SPWM_POLARITY_EN
  // Half-cycle polarity flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pol_q <= 1'b0;
    else        pol_q <= pol_d;
  end
  assign polarity = pol_q;
`else
  assign polarity = 1'b0;
`endif

  assign theta     = theta_q;
  assign pwm_en    = pwm_en_q;
  assign done      = done_q;
  assign burst_cnt = burst_cnt_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spwm_burst_sequencer.sv
// tb_spwm_burst_sequencer: directed stimulus with a scoreboard of expected done
// events (cycle since run entry, burst count) and expected rest-gap lengths.
module tb_spwm_burst_sequencer;

  typedef struct {
    int cyc;
    int cnt;
  } done_exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [15:0] cfg_step_div;
  logic [19:0] cfg_rest;
  logic [7:0]  cfg_bursts;
  logic [9:0]  theta;
  logic        pwm_en;
  logic        polarity;
  logic        busy;
  logic        done;
  logic [7:0]  burst_cnt;

  int errors = 0;
  int checks = 0;

  done_exp_t exp_done[$];
  int        exp_gap[$];

  int   run_cyc = 0;
  int   low_len = 0;
  logic busy_p  = 1'b0;

  spwm_burst_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .cfg_step_div (cfg_step_div),
    .cfg_rest     (cfg_rest),
    .cfg_bursts   (cfg_bursts),
    .theta        (theta),
    .pwm_en       (pwm_en),
    .polarity     (polarity),
    .busy         (busy),
    .done         (done),
    .burst_cnt    (burst_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Monitor: cycle count since run entry, rest-gap lengths, done pulses.
  always @(negedge clk) begin
    done_exp_t e;
    int g;
    if (busy && !busy_p) run_cyc = 0;
    else                 run_cyc++;
    busy_p = busy;
    if (!busy) begin
      low_len = 0;
    end else if (!pwm_en) begin
      low_len++;
    end else if (low_len != 0) begin
      if (exp_gap.size() == 0) begin
        chk("unexpected_gap", low_len, 0);
      end else begin
        g = exp_gap.pop_front();
        chk("gap_len", low_len, g);
      end
      low_len = 0;
    end
    if (done) begin
      if (exp_done.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        e = exp_done.pop_front();
        chk("done_cycle", run_cyc, e.cyc);
        chk("done_cnt", int'(burst_cnt), e.cnt);
      end
    end
  end

  // Issue start; returns at the negedge of the first RUN cycle.
  task automatic do_start(input int div, input int rest, input int bursts);
    @(negedge clk);
    cfg_step_div = 16'(div);
    cfg_rest     = 20'(rest);
    cfg_bursts   = 8'(bursts);
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_theta(input int th, input int cnt, input int budget);
    int n = 0;
    while (!(int'(theta) == th && pwm_en && (cnt < 0 || int'(burst_cnt) == cnt)) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) chk("theta_timeout", 1, 0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    stop         = 1'b0;
    cfg_step_div = '0;
    cfg_rest     = '0;
    cfg_bursts   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_theta", int'(theta), 0);
    chk("rst_pwm_en", int'(pwm_en), 0);
    chk("rst_polarity", int'(polarity), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_burst_cnt", int'(burst_cnt), 0);

    // div=4, single burst: theta k/4, done at cycle 352.
    exp_done.push_back('{cyc: 352, cnt: 1});
    do_start(4, 0, 1);
    for (int k = 0; k < 352; k++) begin
      if (int'(theta) != k / 4 || !pwm_en) chk("t1_theta", int'(theta), k / 4);
      else checks++;
      @(negedge clk);
    end
    wait_idle(20);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_pwm_after", int'(pwm_en), 0);
    chk("t1_cnt_after", int'(burst_cnt), 1);

    // div=2, rest=10, three bursts.
    exp_gap.push_back(10);
    exp_gap.push_back(10);
    exp_done.push_back('{cyc: 548, cnt: 3});
    do_start(2, 10, 3);
    wait_idle(700);
    chk("t2_cnt", int'(burst_cnt), 3);

    // Continuous run, stop at theta=40 in the third burst.
    do_start(1, 0, 0);
    wait_theta(40, 2, 400);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("t3_theta", int'(theta), 0);
    chk("t3_busy", int'(busy), 0);
    chk("t3_pwm_en", int'(pwm_en), 0);
    chk("t3_cnt_hold", int'(burst_cnt), 2);
    repeat (3) @(negedge clk);

    // div=0 as 1; start while busy ignored.
    exp_done.push_back('{cyc: 88, cnt: 1});
    do_start(0, 0, 1);
    repeat (20) @(negedge clk);
    cfg_step_div = 16'd5;
    cfg_bursts   = 8'd2;
    start        = 1'b1;
    @(negedge clk);
    start        = 1'b0;
    repeat (9) @(negedge clk);
    chk("t4_theta30", int'(theta), 30);
    chk("t4_cnt", int'(burst_cnt), 0);
    wait_idle(200);
    chk("t4_cnt_after", int'(burst_cnt), 1);

    // Asynchronous reset during REST, then restart.
    do_start(1, 50, 0);
    begin
      int n = 0;
      while (!(busy && !pwm_en) && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (n >= 200) chk("rest_timeout", 1, 0);
    end
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_theta", int'(theta), 0);
    chk("t5_pwm_en", int'(pwm_en), 0);
    chk("t5_busy", int'(busy), 0);
    chk("t5_done", int'(done), 0);
    chk("t5_cnt", int'(burst_cnt), 0);
    chk("t5_polarity", int'(polarity), 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_done.push_back('{cyc: 88, cnt: 1});
    do_start(1, 0, 1);
    wait_idle(200);

    // Polarity across four bursts with rest=3.
    for (int k = 0; k < 3; k++) exp_gap.push_back(3);
    exp_done.push_back('{cyc: 361, cnt: 4});
    do_start(1, 3, 4);
    for (int k = 0; k < 4; k++) begin
      wait_theta(44, k, 300);
`ifdef SPWM_POLARITY_EN
      chk("t6_polarity", int'(polarity), k % 2);
`else
      chk("t6_polarity", int'(polarity), 0);
`endif
      @(negedge clk);
    end
    wait_idle(400);

    // burst_cnt saturates at 255 in continuous mode.
    do_start(1, 0, 0);
    repeat (256 * 88 + 10) @(negedge clk);
    chk("t7_sat_cnt", int'(burst_cnt), 255);
    chk("t7_busy", int'(busy), 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_cnt_hold", int'(burst_cnt), 255);

    chk("done_queue_empty", exp_done.size(), 0);
    chk("gap_queue_empty", exp_gap.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
